// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic-light timer and the light FSM.
package traffic_pkg;

    typedef enum logic {
        CFG_SHORT = 1'b0,
        CFG_LONG  = 1'b1
    } cfg_sel_e;

    localparam int TS_DEF = 5;
    localparam int TL_DEF = 25;

    typedef enum logic [1:0] {
        HG = 2'd0,
        HY = 2'd1,
        FG = 2'd2,
        FY = 2'd3
    } light_e;

endpackage

// File: rtl/tr_debounce.sv
// Two-flop synchronizer plus run-length debounce of the farm-road sensor.
module tr_debounce #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic tr_raw,
    output logic tr
);

    localparam int DW = $clog2(DEB_LEN + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_LEN - 1);

    logic          sync_a;
    logic          sync_b;
    logic [DW-1:0] dcnt;

    // tr flips on the DEB_LEN-th consecutive disagreeing sample
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            dcnt   <= '0;
            tr     <= 1'b0;
        end else begin
            sync_a <= tr_raw;
            sync_b <= sync_a;
            if (sync_b == tr) begin
                dcnt <= '0;
            end else if (dcnt == DCNT_LAST) begin
                dcnt <= '0;
                tr   <= ~tr;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_timer_ctrl.sv
// Elapsed-seconds timer, programmable short/long limits and sensor debounce
// serving the highway/farm traffic-light FSM.
module traffic_timer_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PRESC_W   = 16,
    parameter int PRESC_DIV = 50000,
    parameter int TS_DEF    = traffic_pkg::TS_DEF,
    parameter int TL_DEF    = traffic_pkg::TL_DEF,
    parameter int DEB_LEN   = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             st,
    input  logic             tr_raw,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             tr,
    output logic             ts,
    output logic             tl,
    output logic             busy,
    output logic             sec_tick
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]   TS_RST     = CNT_W'(TS_DEF);
    localparam logic [CNT_W-1:0]   TL_RST     = CNT_W'(TL_DEF);

    logic [PRESC_W-1:0] pcnt;
    logic [PRESC_W-1:0] pcnt_eff;
    logic [CNT_W-1:0]   ecnt;
    logic [CNT_W-1:0]   ts_sh, tl_sh, ts_act, tl_act;
    logic [CNT_W-1:0]   cfg_val;
    logic               wr_short, wr_long;
    logic               run;
    cfg_sel_e           sel;

    // The st cycle itself counts as prescaler phase 0, so each interval
    // begins with a full second measured from the start pulse.
    assign pcnt_eff = st ? '0 : pcnt;
    assign sec_tick = (pcnt_eff == PRESC_LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pcnt <= '0;
            ecnt <= '0;
        end else begin
            pcnt <= sec_tick ? '0 : pcnt_eff + 1'b1;
            if (st)
                ecnt <= '0;
            else if (sec_tick && ecnt != CNT_MAX)
                ecnt <= ecnt + 1'b1;
        end
    end

    assign sel      = cfg_sel_e'(cfg_sel);
    assign cfg_val  = (cfg_data == '0) ? CNT_W'(1) : cfg_data;
    assign wr_short = cfg_we && (sel == CFG_SHORT);
    assign wr_long  = cfg_we && (sel == CFG_LONG);

    // A write coinciding with st is forwarded straight into the active limit
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ts_sh  <= TS_RST;
            tl_sh  <= TL_RST;
            ts_act <= TS_RST;
            tl_act <= TL_RST;
        end else begin
            if (wr_short) ts_sh <= cfg_val;
            if (wr_long)  tl_sh <= cfg_val;
            if (st) begin
                ts_act <= wr_short ? cfg_val : ts_sh;
                tl_act <= wr_long  ? cfg_val : tl_sh;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            run <= 1'b0;
        else if (st)
            run <= 1'b1;
        else if (tl)
            run <= 1'b0;
    end

    assign ts   = ~st & (ecnt >= ts_act);
    assign tl   = ~st & (ecnt >= tl_act);
    assign busy = st | (run & ~tl);

    tr_debounce #(
        .DEB_LEN (DEB_LEN)
    ) u_deb (
        .clk    (clk),
        .clr_n  (clr_n),
        .tr_raw (tr_raw),
        .tr     (tr)
    );

endmodule

// File: tb/tb_traffic_timer_ctrl.sv
// Directed bench for traffic_timer_ctrl: expectations are queued with an
// absolute cycle number and compared by a negedge checker.
module tb_traffic_timer_ctrl;
    import traffic_pkg::*;

    localparam int S_TS = 0, S_TL = 1, S_BUSY = 2, S_TR = 3, S_TICK = 4;

    logic       clk;
    logic       clr_n;
    logic       st;
    logic       tr_raw;
    logic       cfg_we;
    logic       cfg_sel;
    logic [7:0] cfg_data;
    logic       tr, ts, tl, busy, sec_tick;

    typedef struct {
        string tag;
        int    at;
        int    sig;
        logic  val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    traffic_timer_ctrl #(
        .CNT_W     (8),
        .PRESC_W   (16),
        .PRESC_DIV (4),
        .TS_DEF    (2),
        .TL_DEF    (5),
        .DEB_LEN   (4)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .st       (st),
        .tr_raw   (tr_raw),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .tr       (tr),
        .ts       (ts),
        .tl       (tl),
        .busy     (busy),
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic sig_val(int s);
        case (s)
            S_TS:    return ts;
            S_TL:    return tl;
            S_BUSY:  return busy;
            S_TR:    return tr;
            default: return sec_tick;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            checks++;
            if (e.at < cyc) begin
                assert (e.at === cyc) else begin
                    errors++;
                    $error("FAIL %s missed: due cycle %0d, now %0d", e.tag, e.at, cyc);
                end
            end else begin
                assert (sig_val(e.sig) === e.val) else begin
                    errors++;
                    $error("FAIL %s cycle %0d: observed %b expected %b", e.tag, cyc, sig_val(e.sig), e.val);
                end
            end
        end
    end

    task automatic want(input string tag, input int rel, input int sig, input logic val);
        exp_t e;
        int   i;
        e.tag = tag;
        e.at  = cyc + rel;
        e.sig = sig;
        e.val = val;
        i = 0;
        while (i < sbq.size() && sbq[i].at <= e.at) i++;
        sbq.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    light_e state;
    int     dwq[$];
    int     last_st;
    int     trans;
    int     dwell;

    initial begin
        clr_n = 1'b0; st = 1'b0; tr_raw = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = 8'd0;
        step(2);
        want("rst_ts", 0, S_TS, 1'b0);
        want("rst_tl", 0, S_TL, 1'b0);
        want("rst_busy", 0, S_BUSY, 1'b0);
        want("rst_tr", 0, S_TR, 1'b0);
        want("rst_tick", 0, S_TICK, 1'b0);
        step(1);
        clr_n = 1'b1;
        step(1);

        // basic interval with default limits 2 s / 5 s
        st = 1'b1;
        want("s1_ts_st", 0, S_TS, 1'b0);
        want("s1_tl_st", 0, S_TL, 1'b0);
        want("s1_busy_st", 0, S_BUSY, 1'b1);
        want("s1_tick2", 2, S_TICK, 1'b0);
        want("s1_tick3", 3, S_TICK, 1'b1);
        want("s1_ts7", 7, S_TS, 1'b0);
        want("s1_ts8", 8, S_TS, 1'b1);
        want("s1_tl19", 19, S_TL, 1'b0);
        want("s1_busy19", 19, S_BUSY, 1'b1);
        want("s1_tl20", 20, S_TL, 1'b1);
        want("s1_busy20", 20, S_BUSY, 1'b0);
        want("s1_busy22", 22, S_BUSY, 1'b0);
        step(1); st = 1'b0;
        step(25);

        // long hold: elapsed count saturates instead of wrapping, then restart
        st = 1'b1;
        want("s2_ts_sat", 1026, S_TS, 1'b1);
        want("s2_tl_sat", 1026, S_TL, 1'b1);
        step(1); st = 1'b0;
        step(1030);
        st = 1'b1;
        want("s2_ts_st", 0, S_TS, 1'b0);
        want("s2_tl_st", 0, S_TL, 1'b0);
        want("s2_busy_st", 0, S_BUSY, 1'b1);
        want("s2_ts7", 7, S_TS, 1'b0);
        want("s2_ts8", 8, S_TS, 1'b1);
        step(1); st = 1'b0;
        step(10);

        // mid-interval write to short limit is deferred to the next st
        st = 1'b1;
        want("s3_ts7_old", 7, S_TS, 1'b0);
        want("s3_ts8_old", 8, S_TS, 1'b1);
        step(1); st = 1'b0;
        step(1);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd3;
        step(1); cfg_we = 1'b0;
        step(25);
        st = 1'b1;
        want("s3_ts11_new", 11, S_TS, 1'b0);
        want("s3_ts12_new", 12, S_TS, 1'b1);
        step(1); st = 1'b0;
        step(14);
        st = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd0;
        want("s3_ts_zero_st", 0, S_TS, 1'b0);
        want("s3_ts_zero3", 3, S_TS, 1'b0);
        want("s3_ts_zero4", 4, S_TS, 1'b1);
        step(1); st = 1'b0; cfg_we = 1'b0;
        step(8);

        // st held three cycles with a long-limit write in the first one
        st = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 8'd2;
        want("s3_hold_ts0", 0, S_TS, 1'b0);
        want("s3_hold_ts1", 1, S_TS, 1'b0);
        want("s3_hold_ts2", 2, S_TS, 1'b0);
        want("s3_hold_tl2", 2, S_TL, 1'b0);
        want("s3_hold_ts5", 5, S_TS, 1'b0);
        want("s3_hold_ts6", 6, S_TS, 1'b1);
        want("s3_hold_tl9", 9, S_TL, 1'b0);
        want("s3_hold_tl10", 10, S_TL, 1'b1);
        want("s3_hold_busy10", 10, S_BUSY, 1'b0);
        step(1); cfg_we = 1'b0;
        step(2); st = 1'b0;
        step(12);

        // debounce: short glitch rejected, clean edges after 6 cycles
        tr_raw = 1'b1;
        want("s4_glitch6", 6, S_TR, 1'b0);
        want("s4_glitch10", 10, S_TR, 1'b0);
        step(3); tr_raw = 1'b0;
        step(12);
        tr_raw = 1'b1;
        want("s4_rise5", 5, S_TR, 1'b0);
        want("s4_rise6", 6, S_TR, 1'b1);
        step(10);
        tr_raw = 1'b0;
        want("s4_fall5", 5, S_TR, 1'b1);
        want("s4_fall6", 6, S_TR, 1'b0);
        step(10);

        // reset mid-interval after rewriting both limits
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd7;
        step(1);
        cfg_sel = 1'b1; cfg_data = 8'd9;
        step(1);
        cfg_we = 1'b0; tr_raw = 1'b1; st = 1'b1;
        want("s5_tr14", 14, S_TR, 1'b1);
        want("s5_busy14", 14, S_BUSY, 1'b1);
        want("s5_ts14", 14, S_TS, 1'b0);
        step(1); st = 1'b0;
        step(14);
        clr_n = 1'b0;
        want("s5_rst_ts", 0, S_TS, 1'b0);
        want("s5_rst_tl", 0, S_TL, 1'b0);
        want("s5_rst_busy", 0, S_BUSY, 1'b0);
        want("s5_rst_tr", 0, S_TR, 1'b0);
        want("s5_rst_tick", 0, S_TICK, 1'b0);
        step(2);
        clr_n = 1'b1;
        step(1);
        st = 1'b1;
        want("s5_ts7", 7, S_TS, 1'b0);
        want("s5_ts8", 8, S_TS, 1'b1);
        want("s5_tl19", 19, S_TL, 1'b0);
        want("s5_tl20", 20, S_TL, 1'b1);
        step(1); st = 1'b0;
        step(22);

        // closed loop with a light FSM, farm traffic always present
        st = 1'b1; state = HG; last_st = cyc; trans = 0;
        dwq.push_back(20);
        step(1); st = 1'b0;
        for (int k = 0; k < 400 && trans < 8; k++) begin
            #1;
            if ((state == HG && tl && tr) || (state == HY && ts) ||
                (state == FG && (tl || !tr)) || (state == FY && ts)) begin
                dwell = dwq.pop_front();
                checks++;
                assert ((cyc - last_st) === dwell) else begin
                    errors++;
                    $error("FAIL s6_dwell_%s: observed %0d cycles expected %0d", state.name(), cyc - last_st, dwell);
                end
                case (state)
                    HG: begin state = HY; dwq.push_back(8);  end
                    HY: begin state = FG; dwq.push_back(20); end
                    FG: begin state = FY; dwq.push_back(8);  end
                    default: begin state = HG; dwq.push_back(20); end
                endcase
                st = 1'b1;
                last_st = cyc;
                trans++;
            end
            step(1); st = 1'b0;
        end
        checks++;
        assert (trans === 8) else begin
            errors++;
            $error("FAIL s6_transitions: observed %0d expected %0d", trans, 8);
        end

        step(3);
        checks++;
        assert (sbq.size() === 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected %0d", sbq.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
